// File: rtl/pong_pkg.sv
// Shared types and screen geometry for the Pong game sequencer.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE    = 2'd0,
    ST_PLAY     = 2'd1,
    ST_POINT    = 2'd2,
    ST_GAMEOVER = 2'd3
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int FRAME_W  = 800;
  localparam int FRAME_H  = 525;
  localparam int PAD_W    = 8;
  localparam int PAD_L_X  = 16;
  localparam int PAD_R_X  = 616;
  localparam int CENTRE_X = 316;
  localparam int CENTRE_Y = 236;
  localparam int TICK_H   = 0;
  localparam int TICK_V   = 480;

endpackage

// File: rtl/pong_paddle.sv
// One paddle: moves by PADDLE_SPD per frame tick and clamps inside the playfield.
import pong_pkg::*;

module pong_paddle #(
  parameter int PADDLE_SPD = 4,
  parameter int PADDLE_H   = 64
) (
  input  logic       clk25M,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_en,
  output logic [9:0] o_y
);

  localparam logic [9:0] Y_MAX = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0] SPD   = 10'(PADDLE_SPD);

  logic [9:0] r_y;

  // Both buttons pressed cancel out; clamping avoids unsigned wrap at the top edge.
  always_ff @(posedge clk25M or posedge reset) begin
    if (reset) begin
      r_y <= 10'((SCREEN_H - PADDLE_H) / 2);
    end else if (i_tick && i_en && (i_up != i_down)) begin
      if (i_up) r_y <= (r_y < SPD) ? '0 : r_y - SPD;
      else      r_y <= (r_y > Y_MAX - SPD) ? Y_MAX : r_y + SPD;
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/pong_frame_ctrl.sv
// Pong game sequencer: frame tick from the VGA counters, ball datapath, scoring and game FSM.
//   state       | meaning
//   ST_SERVE    | ball parked at centre, waiting for timeout or start
//   ST_PLAY     | ball moving, walls/paddles/goals evaluated each tick
//   ST_POINT    | ball parked after a score, fixed hold time
//   ST_GAMEOVER | everything frozen until start
import pong_pkg::*;

module pong_frame_ctrl #(
  parameter int BALL_SPD     = 2,
  parameter int PADDLE_SPD   = 4,
  parameter int PADDLE_H     = 64,
  parameter int BALL_SZ      = 8,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk25M,
  input  logic       reset,
  input  logic [9:0] i_hcount,
  input  logic [9:0] i_vcount,
  input  logic [3:0] i_btn,
  input  logic       i_start,
  output logic       o_frame_tick,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic [9:0] o_pad_l_y,
  output logic [9:0] o_pad_r_y,
  output logic [3:0] o_score_l,
  output logic [3:0] o_score_r,
  output logic [1:0] o_state
);

  localparam logic signed [10:0] B_SPD  = 11'(BALL_SPD);
  localparam logic signed [10:0] X_LIM  = 11'(SCREEN_W - BALL_SZ);
  localparam logic signed [10:0] Y_LIM  = 11'(SCREEN_H - BALL_SZ);
  localparam logic signed [10:0] L_HIT  = 11'(PAD_L_X + PAD_W);
  localparam logic signed [10:0] R_HIT  = 11'(PAD_R_X - BALL_SZ);
  localparam logic [9:0]         L_HITU = 10'(PAD_L_X + PAD_W);
  localparam logic [9:0]         R_HITU = 10'(PAD_R_X - BALL_SZ);
  localparam logic [9:0]         CX     = 10'(CENTRE_X);
  localparam logic [9:0]         CY     = 10'(CENTRE_Y);
  localparam logic [3:0]         WIN    = 4'(WIN_SCORE);

  logic        r_frame_tick;
  logic [9:0]  r_ball_x, r_ball_y;
  logic [3:0]  r_score_l, r_score_r;
  state_t      r_state;
  logic [6:0]  r_frame_cnt;
  logic        r_dir_x, r_dir_y;

  logic              w_pad_en;
  logic [9:0]        w_pad_l, w_pad_r;
  logic signed [10:0] w_nx, w_ny;
  logic [10:0]       w_by, w_pl, w_pr;
  logic              w_ov_l, w_ov_r, w_hit_l, w_hit_r;

  assign w_pad_en = (r_state != ST_GAMEOVER);

  pong_paddle #(.PADDLE_SPD(PADDLE_SPD), .PADDLE_H(PADDLE_H)) u_pad_l (
    .clk25M(clk25M), .reset(reset), .i_tick(r_frame_tick), .i_up(i_btn[0]),
    .i_down(i_btn[1]), .i_en(w_pad_en), .o_y(w_pad_l)
  );

  pong_paddle #(.PADDLE_SPD(PADDLE_SPD), .PADDLE_H(PADDLE_H)) u_pad_r (
    .clk25M(clk25M), .reset(reset), .i_tick(r_frame_tick), .i_up(i_btn[2]),
    .i_down(i_btn[3]), .i_en(w_pad_en), .o_y(w_pad_r)
  );

  // 11-bit signed next position so a step past the left/top edge shows up as negative.
  always_comb begin
    w_nx = r_dir_x ? $signed({1'b0, r_ball_x}) + B_SPD : $signed({1'b0, r_ball_x}) - B_SPD;
    w_ny = r_dir_y ? $signed({1'b0, r_ball_y}) + B_SPD : $signed({1'b0, r_ball_y}) - B_SPD;
    w_by = {1'b0, r_ball_y};
    w_pl = {1'b0, w_pad_l};
    w_pr = {1'b0, w_pad_r};
    w_ov_l = (w_by + 11'(BALL_SZ - 1) >= w_pl) && (w_by <= w_pl + 11'(PADDLE_H - 1));
    w_ov_r = (w_by + 11'(BALL_SZ - 1) >= w_pr) && (w_by <= w_pr + 11'(PADDLE_H - 1));
    w_hit_l = !r_dir_x && (w_nx <= L_HIT) && (r_ball_x >= L_HITU) && w_ov_l;
    w_hit_r =  r_dir_x && (w_nx >= R_HIT) && (r_ball_x <= R_HITU) && w_ov_r;
  end

  always_ff @(posedge clk25M or posedge reset) begin
    if (reset) begin
      r_frame_tick <= 1'b0;
      r_ball_x     <= CX;
      r_ball_y     <= CY;
      r_score_l    <= '0;
      r_score_r    <= '0;
      r_state      <= ST_SERVE;
      r_frame_cnt  <= '0;
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b1;
    end else begin
      r_frame_tick <= (i_hcount == 10'(TICK_H)) && (i_vcount == 10'(TICK_V));
      if (r_frame_tick) begin
        case (r_state)
          ST_SERVE: begin
            r_ball_x <= CX;
            r_ball_y <= CY;
            if ((r_frame_cnt == 7'(SERVE_FRAMES - 1)) || i_start) begin
              r_state     <= ST_PLAY;
              r_frame_cnt <= '0;
            end else begin
              r_frame_cnt <= r_frame_cnt + 7'd1;
            end
          end
          ST_PLAY: begin
            if (w_ny[10]) begin
              r_ball_y <= '0;
              r_dir_y  <= 1'b1;
            end else if (w_ny > Y_LIM) begin
              r_ball_y <= Y_LIM[9:0];
              r_dir_y  <= 1'b0;
            end else begin
              r_ball_y <= w_ny[9:0];
            end
            // Paddle hits win over goals; a goal recentres the ball, overriding the y step.
            if (w_hit_l) begin
              r_ball_x <= L_HITU;
              r_dir_x  <= 1'b1;
            end else if (w_hit_r) begin
              r_ball_x <= R_HITU;
              r_dir_x  <= 1'b0;
            end else if (w_nx[10]) begin
              r_score_r <= (r_score_r == WIN) ? WIN : r_score_r + 4'd1;
              r_dir_x   <= 1'b0;
              r_ball_x  <= CX;
              r_ball_y  <= CY;
              r_state   <= ST_POINT;
            end else if (w_nx > X_LIM) begin
              r_score_l <= (r_score_l == WIN) ? WIN : r_score_l + 4'd1;
              r_dir_x   <= 1'b1;
              r_ball_x  <= CX;
              r_ball_y  <= CY;
              r_state   <= ST_POINT;
            end else begin
              r_ball_x <= w_nx[9:0];
            end
          end
          ST_POINT: begin
            r_ball_x <= CX;
            r_ball_y <= CY;
            if (r_frame_cnt == 7'(POINT_FRAMES - 1)) begin
              r_frame_cnt <= '0;
              if ((r_score_l == WIN) || (r_score_r == WIN)) begin
                r_state <= ST_GAMEOVER;
              end else begin
                r_state <= ST_SERVE;
                r_dir_y <= ~r_dir_y;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + 7'd1;
            end
          end
          default: begin
            if (i_start) begin
              r_score_l   <= '0;
              r_score_r   <= '0;
              r_ball_x    <= CX;
              r_ball_y    <= CY;
              r_frame_cnt <= '0;
              r_state     <= ST_SERVE;
            end
          end
        endcase
      end
    end
  end

  assign o_frame_tick = r_frame_tick;
  assign o_ball_x     = r_ball_x;
  assign o_ball_y     = r_ball_y;
  assign o_pad_l_y    = w_pad_l;
  assign o_pad_r_y    = w_pad_r;
  assign o_score_l    = r_score_l;
  assign o_score_r    = r_score_r;
  assign o_state      = r_state;

endmodule
